// File: rtl/bus_interconnect.sv
// bus_interconnect: N-master / M-slave shared-bus interconnect.
//   Round-robin arbitration with one transaction in flight. The granted master's request is
//   latched in IDLE, decoded against per-slave base/mask pairs (lowest matching slave wins) and
//   presented to the selected slave until its ready. Unmapped addresses complete at once with
//   an error. All s_* outputs are zero outside ACCESS and all m_* outputs are zero outside DONE,
//   so they can be OR-combined with other bus segments.
// Optional feature (macro BUS_TIMEOUT_EN): an ACCESS that sees no s_ready on its
//   TIMEOUT_CYCLES-th cycle completes with an error and zero data. Without the macro ACCESS
//   waits indefinitely and TIMEOUT_CYCLES has no effect.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   m_address/m_read/m_write/
//   m_write_mask/m_write_value      per-master request and payload (lane i = master i)
//   m_read_value/m_ready/m_error    per-master completion (one-cycle pulse)
//   s_address/s_read/s_write/
//   s_write_mask/s_write_value      shared slave request, driven only in ACCESS
//   s_sel                           one-hot slave select
//   s_read_value/s_ready            per-slave response (lane j = slave j)
module bus_interconnect #(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned NUM_SLAVES     = 4,
    parameter int unsigned ADDR_W         = 64,
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned MASK_W         = DATA_W / 8,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
        {64'h3_0000, 64'h2_0000, 64'h1_0000, 64'h0},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK =
        {~64'hF, ~64'hF, ~64'h3, ~64'hFFFF},
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
    input  logic [NUM_MASTERS-1:0]        m_read,
    input  logic [NUM_MASTERS-1:0]        m_write,
    input  logic [NUM_MASTERS*MASK_W-1:0] m_write_mask,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_write_value,
    output logic [NUM_MASTERS*DATA_W-1:0] m_read_value,
    output logic [NUM_MASTERS-1:0]        m_ready,
    output logic [NUM_MASTERS-1:0]        m_error,
    output logic [ADDR_W-1:0]             s_address,
    output logic                          s_read,
    output logic                          s_write,
    output logic [MASK_W-1:0]             s_write_mask,
    output logic [DATA_W-1:0]             s_write_value,
    output logic [NUM_SLAVES-1:0]         s_sel,
    input  logic [NUM_SLAVES*DATA_W-1:0]  s_read_value,
    input  logic [NUM_SLAVES-1:0]         s_ready
);

    localparam int unsigned MIDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned SIDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e              state_q, state_d;
    logic [MIDX_W-1:0]   gnt_q, gnt_d;
    logic [MIDX_W-1:0]   rr_q, rr_d;
    logic [SIDX_W-1:0]   sidx_q, sidx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                read_q, read_d;
    logic                write_q, write_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    // Arbitration, payload mux and decode (only consumed in IDLE)
    logic [NUM_MASTERS-1:0] req;
    logic                   gnt_valid;
    logic [MIDX_W-1:0]      gnt_idx;
    logic [MIDX_W-1:0]      cand_idx;
    int unsigned            cand;
    logic [ADDR_W-1:0]      sel_addr;
    logic                   sel_read, sel_write;
    logic [MASK_W-1:0]      sel_mask;
    logic [DATA_W-1:0]      sel_wdata;
    logic                   hit;
    logic [SIDX_W-1:0]      hit_idx;
    // Response of the currently selected slave
    logic                   cur_ready;
    logic [DATA_W-1:0]      cur_rdata;

    always_comb begin
        req       = m_read | m_write;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        // Scan upward from rr_q with wrap; first requester wins
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            cand     = (32'(rr_q) + i) % NUM_MASTERS;
            cand_idx = MIDX_W'(cand);
            if (!gnt_valid && req[cand_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand_idx;
            end
        end

        sel_addr  = '0;
        sel_read  = 1'b0;
        sel_write = 1'b0;
        sel_mask  = '0;
        sel_wdata = '0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (MIDX_W'(i) == gnt_idx) begin
                sel_addr  = m_address[i*ADDR_W +: ADDR_W];
                sel_read  = m_read[i];
                sel_write = m_write[i];
                sel_mask  = m_write_mask[i*MASK_W +: MASK_W];
                sel_wdata = m_write_value[i*DATA_W +: DATA_W];
            end
        end

        // Descending scan so the lowest matching slave index is the one left standing
        hit     = 1'b0;
        hit_idx = '0;
        for (int s = int'(NUM_SLAVES) - 1; s >= 0; s--) begin
            if ((sel_addr & SLAVE_MASK[s*ADDR_W +: ADDR_W]) == SLAVE_BASE[s*ADDR_W +: ADDR_W]) begin
                hit     = 1'b1;
                hit_idx = SIDX_W'(s);
            end
        end

        cur_ready = 1'b0;
        cur_rdata = '0;
        for (int s = 0; s < int'(NUM_SLAVES); s++) begin
            if (SIDX_W'(s) == sidx_q) begin
                cur_ready = s_ready[s];
                cur_rdata = s_read_value[s*DATA_W +: DATA_W];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout;

    // Counter is zero on the first ACCESS cycle and counts ACCESS cycles elapsed
    assign cnt_d   = (state_q == StAccess) ? cnt_q + 1'b1 : '0;
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            rr_q    <= '0;
            sidx_q  <= '0;
            addr_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            mask_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            sidx_q  <= sidx_d;
            addr_q  <= addr_d;
            read_q  <= read_d;
            write_q <= write_d;
            mask_q  <= mask_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        sidx_d  = sidx_q;
        addr_d  = addr_q;
        read_d  = read_q;
        write_d = write_q;
        mask_d  = mask_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    gnt_d   = gnt_idx;
                    addr_d  = sel_addr;
                    // Read+write together is a write
                    read_d  = sel_read & ~sel_write;
                    write_d = sel_write;
                    mask_d  = sel_mask;
                    wdata_d = sel_wdata;
                    rdata_d = '0;
                    sidx_d  = hit_idx;
                    err_d   = ~hit;
                    state_d = hit ? StAccess : StDone;
                end
            end
            StAccess: begin
                if (cur_ready) begin
                    rdata_d = write_q ? '0 : cur_rdata;
                    err_d   = 1'b0;
                    state_d = StDone;
                end
`ifdef BUS_TIMEOUT_EN
                else if (timeout) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end
`endif
            end
            StDone: begin
                rr_d    = (gnt_q == MIDX_W'(NUM_MASTERS - 1)) ? '0 : gnt_q + 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        s_address     = '0;
        s_read        = 1'b0;
        s_write       = 1'b0;
        s_write_mask  = '0;
        s_write_value = '0;
        s_sel         = '0;
        m_read_value  = '0;
        m_ready       = '0;
        m_error       = '0;
        if (state_q == StAccess) begin
            s_address     = addr_q;
            s_read        = read_q;
            s_write       = write_q;
            s_write_mask  = mask_q;
            s_write_value = wdata_q;
            for (int s = 0; s < int'(NUM_SLAVES); s++) begin
                if (SIDX_W'(s) == sidx_q) s_sel[s] = 1'b1;
            end
        end
        if (state_q == StDone) begin
            for (int i = 0; i < int'(NUM_MASTERS); i++) begin
                if (MIDX_W'(i) == gnt_q) begin
                    m_ready[i]                      = 1'b1;
                    m_error[i]                      = err_q;
                    m_read_value[i*DATA_W +: DATA_W] = rdata_q;
                end
            end
        end
    end

endmodule
